// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder: FSM states, data and
// counter widths, and the address legality test used when checking is enabled.
package mem_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_e;

   // An address is legal when word aligned and it fits inside the array.
   function automatic logic addr_bad(input logic [31:0] addr, input int addr_w);
      logic [31:0] upper;
      upper = addr >> (addr_w + 2);
      return (addr[1:0] != 2'b00) || (upper != 32'd0);
   endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port word storage: synchronous write, registered read whose output
// holds its value until the next read. Contents are never reset.
module ram_array
   import mem_pkg::*;
#(
   parameter int ADDR_W = 11
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q, rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (re) rdata_d = mem[addr];
   end

   always_ff @(posedge clk) begin
      if (rst) rdata_q <= '0;
      else     rdata_q <= rdata_d;
   end

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: IDLE -> BUSY (WAIT_CYCLES) -> RESP.
// Define MEM_ADDR_CHECK_EN to flag misaligned/out-of-range addresses on err.
module mem_responder
   import mem_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int ADDR_W      = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        waiting,
   output logic [31:0] rdata,
   output logic        resp_valid,
   output logic        err
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             we_q, we_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic             waiting_q, waiting_d;
   logic             resp_valid_q, resp_valid_d;

   logic             cur_we;
   logic [31:0]      cur_addr;
   logic             bad;
   logic             enter_resp;
   logic             resp_err;
   logic             ram_we, ram_re;
   logic [31:0]      ram_rdata;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = CNT_W'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES > 0) ? BUSY : RESP;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= CNT_W'(1)) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      waiting_d    = (state_d == BUSY);
      resp_valid_d = (state_d == RESP);
   end

   // With zero wait the RAM read happens on the accept edge, before the
   // request registers are loaded, so look through to the live inputs in IDLE.
   assign cur_we     = (state_q == IDLE) ? req_we   : we_q;
   assign cur_addr   = (state_q == IDLE) ? req_addr : addr_q;
   assign enter_resp = (state_d == RESP) && (state_q != RESP);

`ifdef MEM_ADDR_CHECK_EN
   logic err_q, err_d;
   logic rd_zero_q, rd_zero_d;

   assign bad = addr_bad(cur_addr, ADDR_W);

   always_comb begin
      err_d     = enter_resp && bad;
      rd_zero_d = rd_zero_q;
      if (enter_resp && !cur_we) rd_zero_d = bad;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q     <= 1'b0;
         rd_zero_q <= 1'b0;
      end else begin
         err_q     <= err_d;
         rd_zero_q <= rd_zero_d;
      end
   end

   assign resp_err = err_q;
   assign err      = err_q;
   assign rdata    = rd_zero_q ? 32'd0 : ram_rdata;
`else
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr_q[31:ADDR_W+2], addr_q[1:0]};
   assign bad      = 1'b0;
   assign resp_err = 1'b0;
   assign err      = 1'b0;
   assign rdata    = ram_rdata;
`endif

   // Writes commit on the edge that ends RESP; reset on that edge aborts them.
   assign ram_re = enter_resp && !cur_we && !bad && !rst;
   assign ram_we = (state_q == RESP) && we_q && !resp_err && !rst;

   ram_array #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (cur_addr[ADDR_W+1:2]),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         waiting_q    <= 1'b0;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         waiting_q    <= waiting_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   assign waiting    = waiting_q;
   assign resp_valid = resp_valid_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder: one DUT with WAIT_CYCLES=2
// and one with WAIT_CYCLES=0, checked against an index-keyed memory model.
module tb_mem_responder;

   localparam int AW = 11;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        a_valid, a_we, a_waiting, a_resp, a_err;
   logic [31:0] a_addr, a_wdata, a_rdata;
   logic        b_valid, b_we, b_waiting, b_resp, b_err;
   logic [31:0] b_addr, b_wdata, b_rdata;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mdl_a [int];
   logic [31:0] mdl_b [int];

   mem_responder #(.WAIT_CYCLES(2), .ADDR_W(AW)) dut_a (
      .clk(clk), .rst(rst), .req_valid(a_valid), .req_we(a_we),
      .req_addr(a_addr), .req_wdata(a_wdata), .waiting(a_waiting),
      .rdata(a_rdata), .resp_valid(a_resp), .err(a_err)
   );

   mem_responder #(.WAIT_CYCLES(0), .ADDR_W(AW)) dut_b (
      .clk(clk), .rst(rst), .req_valid(b_valid), .req_we(b_we),
      .req_addr(b_addr), .req_wdata(b_wdata), .waiting(b_waiting),
      .rdata(b_rdata), .resp_valid(b_resp), .err(b_err)
   );

   function automatic int idx_of(input logic [31:0] a);
      return int'(a[AW+1:2]);
   endfunction

   function automatic bit bad_of(input logic [31:0] a);
`ifdef MEM_ADDR_CHECK_EN
      return (a % 4 != 0) || (a >= (32'd4 << AW));
`else
      return 1'b0;
`endif
   endfunction

   task automatic drive(input bit d0, input bit v, input bit we,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (d0) begin b_valid = v; b_we = we; b_addr = addr; b_wdata = wdata; end
      else    begin a_valid = v; a_we = we; a_addr = addr; a_wdata = wdata; end
   endtask

   // One request from IDLE; returns response latency (cycles after accept),
   // number of waiting cycles, and whether resp_valid was seen the cycle after.
   task automatic access(input bit d0, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat, output int nwait,
                         output logic rv_after);
      lat = -1; nwait = 0; rdata = 'x; err = 'x;
      drive(d0, 1'b1, we, addr, wdata);
      @(posedge clk); #1;
      drive(d0, 1'b0, ~we, ~addr, $urandom);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (d0 ? b_waiting : a_waiting) nwait++;
         if (d0 ? b_resp : a_resp) begin
            lat = k;
            rdata = d0 ? b_rdata : a_rdata;
            err = d0 ? b_err : a_err;
            break;
         end
      end
      @(negedge clk);
      rv_after = d0 ? b_resp : a_resp;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h1);
      drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({a_waiting, a_resp, a_err, b_waiting, b_resp, b_err} !== 6'b0) begin
         failures++;
         $display("FAIL rst_ctrl: got %b want 000000",
                  {a_waiting, a_resp, a_err, b_waiting, b_resp, b_err});
      end
      checks++;
      if (a_rdata !== 32'd0 || b_rdata !== 32'd0) begin
         failures++;
         $display("FAIL rst_rdata: got %h/%h want 0/0", a_rdata, b_rdata);
      end
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read;
      logic [31:0] rd; logic e, rv; int lat, nw;
      access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rd, e, lat, nw, rv);
      mdl_a[idx_of(32'h10)] = 32'hDEADBEEF;
      checks++;
      if (lat !== 3 || nw !== 2 || rv !== 1'b0 || e !== 1'b0) begin
         failures++;
         $display("FAIL wr_timing: got lat=%0d wait=%0d next=%b err=%b want 3 2 0 0", lat, nw, rv, e);
      end
      access(1'b0, 1'b0, 32'h10, 32'h0, rd, e, lat, nw, rv);
      checks++;
      if (lat !== 3 || nw !== 2 || rv !== 1'b0) begin
         failures++;
         $display("FAIL rd_timing: got lat=%0d wait=%0d next=%b want 3 2 0", lat, nw, rv);
      end
      checks++;
      if (rd !== mdl_a[idx_of(32'h10)]) begin
         failures++;
         $display("FAIL rd_data: got %h want %h", rd, mdl_a[idx_of(32'h10)]);
      end
   endtask

   task automatic test_zero_wait;
      logic [31:0] rd; logic e, rv; int lat, nw;
      access(1'b1, 1'b1, 32'h0, 32'h12345678, rd, e, lat, nw, rv);
      mdl_b[0] = 32'h12345678;
      checks++;
      if (lat !== 1 || nw !== 0 || rv !== 1'b0) begin
         failures++;
         $display("FAIL w0_wr_timing: got lat=%0d wait=%0d next=%b want 1 0 0", lat, nw, rv);
      end
      access(1'b1, 1'b0, 32'h0, 32'h0, rd, e, lat, nw, rv);
      checks++;
      if (lat !== 1 || nw !== 0 || rd !== mdl_b[0]) begin
         failures++;
         $display("FAIL w0_rd: got lat=%0d wait=%0d data=%h want 1 0 %h", lat, nw, rd, mdl_b[0]);
      end
   endtask

   // req_valid held high; the address changes every cycle, so only the
   // addresses presented in accepting cycles may come back.
   task automatic test_back_to_back;
      logic [31:0] pool [3];
      logic [31:0] rd; logic e, rv; int lat, nw;
      int bad_rv, bad_wt, bad_data;
      bad_rv = 0; bad_wt = 0; bad_data = 0;
      for (int j = 0; j < 3; j++) begin
         pool[j] = 32'h40 + 32'(4 * j);
         mdl_a[idx_of(pool[j])] = $urandom;
         access(1'b0, 1'b1, pool[j], mdl_a[idx_of(pool[j])], rd, e, lat, nw, rv);
      end
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b1, 1'b0, pool[i % 3], $urandom);
         @(negedge clk);
         if (a_resp !== (i % 4 == 3)) bad_rv++;
         if (a_waiting !== (i % 4 == 1 || i % 4 == 2)) bad_wt++;
         if (i % 4 == 3 && a_rdata !== mdl_a[idx_of(pool[(i - 3) % 3])]) bad_data++;
         @(posedge clk); #1;
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      checks++;
      if (bad_rv != 0 || bad_wt != 0) begin
         failures++;
         $display("FAIL b2b_cadence: got %0d resp / %0d waiting errors want 0", bad_rv, bad_wt);
      end
      checks++;
      if (bad_data != 0) begin
         failures++;
         $display("FAIL b2b_data: got %0d wrong reads want 0", bad_data);
      end
   endtask

   task automatic test_reset_abort;
      logic [31:0] rd; logic e, rv; int lat, nw, seen;
      access(1'b0, 1'b1, 32'h20, 32'h11111111, rd, e, lat, nw, rv);
      mdl_a[idx_of(32'h20)] = 32'h11111111;
      drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (a_waiting !== 1'b1) begin
         failures++;
         $display("FAIL abort_busy: got waiting=%b want 1", a_waiting);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (a_waiting !== 1'b0 || a_resp !== 1'b0 || a_rdata !== 32'd0) begin
         failures++;
         $display("FAIL abort_state: got wait=%b resp=%b rdata=%h want 0 0 0", a_waiting, a_resp, a_rdata);
      end
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (a_resp) seen++;
      end
      checks++;
      if (seen != 0) begin
         failures++;
         $display("FAIL abort_pulse: got %0d responses want 0", seen);
      end
      @(posedge clk); #1;
      access(1'b0, 1'b0, 32'h20, 32'h0, rd, e, lat, nw, rv);
      checks++;
      if (rd !== mdl_a[idx_of(32'h20)]) begin
         failures++;
         $display("FAIL abort_mem: got %h want %h", rd, mdl_a[idx_of(32'h20)]);
      end
   endtask

   task automatic test_addr_check;
      logic [31:0] rd; logic e, rv; int lat, nw;
`ifdef MEM_ADDR_CHECK_EN
      access(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, rd, e, lat, nw, rv);
      mdl_a[idx_of(32'h20)] = 32'hCAFEF00D;
      access(1'b0, 1'b1, 32'h22, 32'h0BADF00D, rd, e, lat, nw, rv);
      checks++;
      if (e !== 1'b1 || lat !== 3) begin
         failures++;
         $display("FAIL chk_wr_err: got err=%b lat=%0d want 1 3", e, lat);
      end
      access(1'b0, 1'b0, 32'h20, 32'h0, rd, e, lat, nw, rv);
      checks++;
      if (rd !== mdl_a[idx_of(32'h20)] || e !== 1'b0) begin
         failures++;
         $display("FAIL chk_mem: got %h err=%b want %h 0", rd, e, mdl_a[idx_of(32'h20)]);
      end
      access(1'b0, 1'b0, 32'h00002000, 32'h0, rd, e, lat, nw, rv);
      checks++;
      if (e !== 1'b1 || rd !== 32'd0) begin
         failures++;
         $display("FAIL chk_rd_err: got err=%b rdata=%h want 1 0", e, rd);
      end
`else
      access(1'b0, 1'b1, 32'h00002004, 32'h77, rd, e, lat, nw, rv);
      mdl_a[idx_of(32'h00002004)] = 32'h77;
      checks++;
      if (e !== 1'b0) begin
         failures++;
         $display("FAIL wrap_err: got %b want 0", e);
      end
      access(1'b0, 1'b0, 32'h4, 32'h0, rd, e, lat, nw, rv);
      checks++;
      if (rd !== 32'h77 || e !== 1'b0) begin
         failures++;
         $display("FAIL wrap_rd: got %h err=%b want 00000077 0", rd, e);
      end
`endif
   endtask

   task automatic test_random;
      logic [31:0] rd, addr, wd, exp; logic e, rv, we; int lat, nw, bad_t, bad_d, bad_e;
      bad_t = 0; bad_d = 0; bad_e = 0;
      for (int n = 0; n < 40; n++) begin
         addr = {$urandom_range(15, 0), 2'b00};
`ifdef MEM_ADDR_CHECK_EN
         if ($urandom_range(3, 0) == 0) addr = addr | 32'($urandom_range(3, 1));
`else
         addr = addr | {$urandom, 13'd0} | 32'($urandom_range(3, 0));
`endif
         we = $urandom_range(1, 0);
         wd = $urandom;
         access(1'b0, we, addr, wd, rd, e, lat, nw, rv);
         if (lat != 3 || nw != 2 || rv !== 1'b0) bad_t++;
         if (e !== bad_of(addr)) bad_e++;
         if (we && !bad_of(addr)) mdl_a[idx_of(addr)] = wd;
         if (!we) begin
            if (bad_of(addr)) begin
               if (rd !== 32'd0) bad_d++;
            end else if (mdl_a.exists(idx_of(addr))) begin
               exp = mdl_a[idx_of(addr)];
               if (rd !== exp) bad_d++;
            end
         end
      end
      checks++;
      if (bad_t != 0) begin
         failures++;
         $display("FAIL rand_timing: got %0d bad accesses want 0", bad_t);
      end
      checks++;
      if (bad_d != 0 || bad_e != 0) begin
         failures++;
         $display("FAIL rand_data: got %0d data / %0d err errors want 0", bad_d, bad_e);
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      test_reset;
      test_write_read;
      test_zero_wait;
      test_back_to_back;
      test_reset_abort;
      test_addr_check;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
